// File: rtl/tug_match_scoreboard.sv
// rtl/tug_match_scoreboard.sv - multi-round tug-of-war winner detection, scoring and hold/clear sequencing
module tug_match_scoreboard #(
    parameter int PLAYERS     = 2,
    parameter int WIN_SCORE   = 3,
    parameter int SCORE_W     = 3,
    parameter int HOLD_CYCLES = 50
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [PLAYERS-1:0]             at_end,
    input  logic [PLAYERS-1:0]             key,
    output logic [6:0]                     hex,
    output logic [$clog2(PLAYERS+1)-1:0]   winner_id,
    output logic [PLAYERS*SCORE_W-1:0]     scores,
    output logic                           round_over,
    output logic                           clear_field,
    output logic                           match_over
);

    localparam int ID_W  = $clog2(PLAYERS + 1);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        HOLD  = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               win_hit;
    logic               win_last;
    logic [ID_W-1:0]    win_id;
    logic               hold_done;

    // Identify the sole qualifying presser; any second key press voids the cycle
    always_comb begin
        win_hit  = 1'b0;
        win_last = 1'b0;
        win_id   = '0;
        if ($onehot(key)) begin
            for (int i = 0; i < PLAYERS; i++) begin
                if (key[i] && at_end[i]) begin
                    win_hit  = 1'b1;
                    win_id   = ID_W'(i + 1);
                    win_last = (scores[i*SCORE_W +: SCORE_W] == SCORE_W'(WIN_SCORE - 1));
                end
            end
        end
    end

    assign hold_done = (state == HOLD) && (cnt == CNT_W'(HOLD_CYCLES - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PLAY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a deciding win goes straight to MATCH, others pause in HOLD
    always_comb begin
        next_state = state;
        case (state)
            PLAY: begin
                if (win_hit) begin
                    next_state = win_last ? MATCH : HOLD;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    next_state = PLAY;
                end
            end
            MATCH:   next_state = MATCH;
            default: next_state = PLAY;
        endcase
    end

    // State-derived outputs
    always_comb begin
        round_over  = (state == HOLD);
        match_over  = (state == MATCH);
        clear_field = hold_done;
    end

    // Scores, displayed winner and hold counter; MATCH freezes everything
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            winner_id <= '0;
            scores    <= '0;
        end else begin
            case (state)
                PLAY: begin
                    if (win_hit) begin
                        winner_id <= win_id;
                        cnt       <= '0;
                        for (int i = 0; i < PLAYERS; i++) begin
                            if (key[i]) begin
                                scores[i*SCORE_W +: SCORE_W] <=
                                    scores[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        cnt       <= '0;
                        winner_id <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Seven-segment decode of the current winner, blank when none
    always_comb begin
        hex = 7'b1111111;
        case (4'(winner_id))
            4'd1:    hex = 7'b1111001;
            4'd2:    hex = 7'b0100100;
            4'd3:    hex = 7'b0110000;
            4'd4:    hex = 7'b0011001;
            4'd5:    hex = 7'b0010010;
            4'd6:    hex = 7'b0000010;
            4'd7:    hex = 7'b1111000;
            4'd8:    hex = 7'b0000000;
            4'd9:    hex = 7'b0010000;
            default: hex = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_tug_match_scoreboard.sv
// tb/tb_tug_match_scoreboard.sv - self-checking bench for tug_match_scoreboard across three builds
module tb_tug_match_scoreboard;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Build 0: defaults. Build 1: four players, short hold. Build 2: three players, one-cycle hold.
    int np [3] = '{2, 4, 3};
    int ws [3] = '{3, 2, 2};
    int sw [3] = '{3, 2, 3};
    int hc [3] = '{50, 4, 1};

    logic       rst    [3];
    logic [8:0] in_at  [3];
    logic [8:0] in_key [3];

    logic [6:0]  o_hex [3];
    logic [3:0]  o_wid [3];
    logic [26:0] o_sc  [3];
    logic        o_ro  [3];
    logic        o_cf  [3];
    logic        o_mo  [3];

    logic [1:0] wid0;
    logic [2:0] wid1;
    logic [1:0] wid2;
    logic [5:0] sc0;
    logic [7:0] sc1;
    logic [8:0] sc2;

    tug_match_scoreboard u_dut0 (
        .clock(clock), .reset(rst[0]), .at_end(in_at[0][1:0]), .key(in_key[0][1:0]),
        .hex(o_hex[0]), .winner_id(wid0), .scores(sc0),
        .round_over(o_ro[0]), .clear_field(o_cf[0]), .match_over(o_mo[0])
    );

    tug_match_scoreboard #(.PLAYERS(4), .WIN_SCORE(2), .SCORE_W(2), .HOLD_CYCLES(4)) u_dut1 (
        .clock(clock), .reset(rst[1]), .at_end(in_at[1][3:0]), .key(in_key[1][3:0]),
        .hex(o_hex[1]), .winner_id(wid1), .scores(sc1),
        .round_over(o_ro[1]), .clear_field(o_cf[1]), .match_over(o_mo[1])
    );

    tug_match_scoreboard #(.PLAYERS(3), .WIN_SCORE(2), .SCORE_W(3), .HOLD_CYCLES(1)) u_dut2 (
        .clock(clock), .reset(rst[2]), .at_end(in_at[2][2:0]), .key(in_key[2][2:0]),
        .hex(o_hex[2]), .winner_id(wid2), .scores(sc2),
        .round_over(o_ro[2]), .clear_field(o_cf[2]), .match_over(o_mo[2])
    );

    assign o_wid[0] = {2'b0, wid0};
    assign o_wid[1] = {1'b0, wid1};
    assign o_wid[2] = {2'b0, wid2};
    assign o_sc[0]  = {21'b0, sc0};
    assign o_sc[1]  = {19'b0, sc1};
    assign o_sc[2]  = {18'b0, sc2};

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] hex_of(input int w);
        case (w)
            0: return 7'b1111111;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // Reference model: scores per player, shown winner, hold cycles left, match decided
    int m_sc   [3][9];
    int m_win  [3];
    int m_hold [3];
    bit m_done [3];

    always @(posedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                for (int p = 0; p < 9; p++) m_sc[d][p] = 0;
                m_win[d]  = 0;
                m_hold[d] = 0;
                m_done[d] = 1'b0;
            end else if (m_done[d]) begin
            end else if (m_hold[d] > 0) begin
                m_hold[d] = m_hold[d] - 1;
                if (m_hold[d] == 0) m_win[d] = 0;
            end else if ($countones(in_key[d]) == 1) begin
                for (int p = 0; p < np[d]; p++) begin
                    if (in_key[d][p] && in_at[d][p]) begin
                        m_sc[d][p] = m_sc[d][p] + 1;
                        m_win[d]   = p + 1;
                        if (m_sc[d][p] == ws[d]) m_done[d] = 1'b1;
                        else                     m_hold[d] = hc[d];
                    end
                end
            end
        end
    end

    // Compare every build against the model on each falling edge
    always @(negedge clock) begin
        if (checking) begin
            for (int d = 0; d < 3; d++) begin
                logic [26:0] esc;
                esc = '0;
                for (int p = 0; p < np[d]; p++) esc = esc | (27'(m_sc[d][p]) << (p * sw[d]));
                chk($sformatf("d%0d scores", d), 32'(o_sc[d]), 32'(esc));
                chk($sformatf("d%0d winner_id", d), 32'(o_wid[d]), 32'(m_win[d]));
                chk($sformatf("d%0d hex", d), 32'(o_hex[d]), 32'(hex_of(m_win[d])));
                chk($sformatf("d%0d round_over", d), 32'(o_ro[d]), 32'(m_hold[d] > 0));
                chk($sformatf("d%0d clear_field", d), 32'(o_cf[d]), 32'(m_hold[d] == 1));
                chk($sformatf("d%0d match_over", d), 32'(o_mo[d]), 32'(m_done[d]));
            end
        end
    end

    // Called at a falling edge: apply inputs for one rising edge, then release
    task automatic press(input int d, input logic [8:0] a, input logic [8:0] k);
        in_at[d]  = a;
        in_key[d] = k;
        @(negedge clock);
        in_at[d]  = '0;
        in_key[d] = '0;
    endtask

    task automatic pulse_reset(input int d);
        rst[d] = 1'b1;
        @(negedge clock);
        rst[d] = 1'b0;
    endtask

    initial begin
        int n_clear;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            in_at[d] = '0;
            in_key[d] = '0;
        end
        @(negedge clock);
        @(negedge clock);
        checking = 1'b1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        chk("reset hex", 32'(o_hex[0]), 32'h7F);
        chk("reset scores", o_sc[0], 32'h0);
        chk("reset winner", 32'(o_wid[0]), 32'h0);

        // First round: player 0 wins
        press(0, 9'b01, 9'b01);
        chk("win0 scores", o_sc[0], 32'h01);
        chk("win0 winner", 32'(o_wid[0]), 32'h1);
        chk("win0 hex", 32'(o_hex[0]), 32'b1111001);
        chk("win0 round_over", 32'(o_ro[0]), 32'h1);
        n_clear = 0;
        repeat (55) begin
            if (o_cf[0]) n_clear++;
            @(negedge clock);
        end
        chk("hold clear count", 32'(n_clear), 32'h1);
        chk("hold winner cleared", 32'(o_wid[0]), 32'h0);

        // Two keys at once void the cycle
        press(0, 9'b01, 9'b11);
        chk("dual hex", 32'(o_hex[0]), 32'h7F);
        chk("dual round_over", 32'(o_ro[0]), 32'h0);
        chk("dual scores", o_sc[0], 32'h01);

        // Player 1 holds key for three cycles: only one point
        in_at[0] = 9'b10;
        in_key[0] = 9'b10;
        repeat (3) @(negedge clock);
        in_at[0] = '0;
        in_key[0] = '0;
        chk("held key scores", o_sc[0], 32'h09);
        repeat (55) @(negedge clock);
        press(0, 9'b10, 9'b10);
        repeat (55) @(negedge clock);
        press(0, 9'b11, 9'b10);
        chk("match over", 32'(o_mo[0]), 32'h1);
        chk("match hex", 32'(o_hex[0]), 32'b0100100);
        chk("match scores", o_sc[0], 32'h19);
        chk("match no clear", 32'(o_cf[0]), 32'h0);
        press(0, 9'b01, 9'b01);
        repeat (3) @(negedge clock);
        chk("match frozen scores", o_sc[0], 32'h19);
        chk("match frozen winner", 32'(o_wid[0]), 32'h2);

        // Reset in MATCH, then reset mid-HOLD
        pulse_reset(0);
        chk("rst match scores", o_sc[0], 32'h0);
        chk("rst match over", 32'(o_mo[0]), 32'h0);
        chk("rst match hex", 32'(o_hex[0]), 32'h7F);
        press(0, 9'b01, 9'b01);
        repeat (10) @(negedge clock);
        chk("mid hold round_over", 32'(o_ro[0]), 32'h1);
        pulse_reset(0);
        chk("rst hold round_over", 32'(o_ro[0]), 32'h0);
        chk("rst hold scores", o_sc[0], 32'h0);
        chk("rst hold winner", 32'(o_wid[0]), 32'h0);

        // Four players: player 3 wins, a press during HOLD is ignored
        press(1, 9'b1000, 9'b1000);
        chk("p4 winner", 32'(o_wid[1]), 32'h4);
        chk("p4 hex", 32'(o_hex[1]), 32'b0011001);
        press(1, 9'b0001, 9'b0001);
        chk("p4 hold ignored", o_sc[1], 32'h40);
        repeat (6) @(negedge clock);
        chk("p4 hold ended", 32'(o_ro[1]), 32'h0);

        // One-cycle hold: round_over and clear_field together, next press accepted right after
        press(2, 9'b001, 9'b001);
        chk("h1 round_over", 32'(o_ro[2]), 32'h1);
        chk("h1 clear", 32'(o_cf[2]), 32'h1);
        @(negedge clock);
        chk("h1 back to play", 32'(o_ro[2]), 32'h0);
        press(2, 9'b010, 9'b010);
        chk("h1 next winner", 32'(o_wid[2]), 32'h2);
        chk("h1 next scores", o_sc[2], 32'h009);
        repeat (2) @(negedge clock);
        press(2, 9'b010, 9'b010);
        chk("h1 match", 32'(o_mo[2]), 32'h1);
        chk("h1 match no clear", 32'(o_cf[2]), 32'h0);
        repeat (3) @(negedge clock);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_match_scoreboard.md
# tug_match_scoreboard

Multi-player, multi-round successor to the single-round tug-of-war winner latch. Watches each player's "marker at my end" flag and key press, awards the round to the sole player pressing while at their end, and keeps per-player scores. After a fixed display hold it pulses a playfield clear, then starts the next round. The match ends when a player reaches `WIN_SCORE`. Sits between the playfield LED logic, the debounced key edge detectors, and the HEX display.

## Interface
- `PLAYERS`, 2: number of players, 2..9.
- `WIN_SCORE`, 3: round wins needed to take the match, 1..2^`SCORE_W`-1.
- `SCORE_W`, 3: bits per score counter.
- `HOLD_CYCLES`, 50: cycles a round result is displayed before the field is cleared, ≥1.
- `clock`  in  1  system clock; everything is updated on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `at_end`  in  `PLAYERS`  bit i = player i's marker is at player i's winning end (level).
- `key`  in  `PLAYERS`  bit i = player i key press (one-cycle pulse from an upstream edge detector).
- `hex`  out  7  active-low seven-segment: digit of the current winner, or blank.
- `winner_id`  out  `$clog2(PLAYERS+1)`  0 = none; i+1 = player i.
- `scores`  out  `PLAYERS*SCORE_W`  packed counters; player i at bits [i*SCORE_W +: SCORE_W].
- `round_over`  out  1  high while a round result is being held.
- `clear_field`  out  1  one-cycle pulse that resets the playfield.
- `match_over`  out  1  high once the match is decided; held until reset.

## Operation
- States: PLAY, HOLD, MATCH. Reset → PLAY.
- Win condition for player i: `at_end[i] & key[i]`, and `key` has exactly one bit set (one-hot). Any simultaneous key press by another player voids the cycle. Extra `at_end` bits without a matching key are ignored.
- PLAY, condition true for player i: `score[i]` increments and `winner_id` ← i+1.
  - If the new score equals `WIN_SCORE`, the next state is MATCH.
  - Otherwise the next state is HOLD and the hold counter is set to 0.
- PLAY, condition false: no change.
- HOLD: the counter increments each cycle. `clear_field` = (HOLD and counter == `HOLD_CYCLES`-1). On that edge: state → PLAY, `winner_id` → 0, counter → 0. Inputs are ignored in HOLD.
- MATCH: terminal state. Scores and `winner_id` are frozen, inputs are ignored, `clear_field` is never asserted. Only reset leaves MATCH.
- Scores never exceed `WIN_SCORE`, so no wrap occurs. Scores persist across rounds and are cleared only by reset.
- `hex` is decoded from `winner_id`:
  - 0 → 1111111 (blank)
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
- `round_over` = (state == HOLD). `match_over` = (state == MATCH).

## Timing
- Reset values: state PLAY, all scores 0, `winner_id` 0, `hex` 1111111, `round_over` 0, `clear_field` 0, `match_over` 0, counter 0.
- Reset dominates every other event, including mid-HOLD and in MATCH.
- Latency: when the win condition is sampled true at edge k, `winner_id`, `hex`, `scores`, and `round_over`/`match_over` all change immediately after edge k. There is no combinational input-to-output path.
- `round_over` stays high for exactly `HOLD_CYCLES` cycles. `clear_field` is high only during the last of those cycles. The first new round press is accepted at the edge after `round_over` falls.
- `HOLD_CYCLES` = 1: `round_over` and `clear_field` are both high for a single cycle.
- A key held for multiple cycles in PLAY can only score once: the first qualifying edge moves the FSM out of PLAY.

## Test plan
- Reset, then `at_end`=01 and `key`=01 for one cycle (PLAYERS=2) → next cycle: `scores`[0]=1, `winner_id`=1, `hex`=1111001, `round_over`=1. After 50 cycles, `clear_field` pulses once and `winner_id` returns to 0.
- Simultaneous keys: `at_end`=01, `key`=11 → no score change, state stays PLAY, `hex` stays 1111111.
- Player 1 wins three rounds (WIN_SCORE=3) → after the third win: `match_over`=1, `hex`=0100100, `scores`[1]=3, no `clear_field`. Further presses change nothing.
- PLAYERS=4: player 3 wins → `winner_id`=4, `hex`=0011001. A press during HOLD is ignored.
- Reset asserted mid-HOLD, and again in MATCH → all outputs return to their reset values on the next cycle, and scores read 0.
- HOLD_CYCLES=1 build: after a win, `round_over`=1 and `clear_field`=1 in the same single cycle. A new win is accepted on the following edge.
